// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array controller.
// State encoding, default sizes and a counter-width helper.
package systolic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_CLEAR,
        S_COMPUTE,
        S_FLUSH,
        S_OUTPUT,
        S_DONE
    } state_e;

    localparam int DEF_ARRAY_SIZE = 2;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ACC_WIDTH  = 32;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_ctrl.sv
// Job sequencer for a weight-stationary systolic array:
// load weights, clear, stream activations, flush, hand off results.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE   = DEF_ARRAY_SIZE,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH    = DEF_ACC_WIDTH,
    parameter int FLUSH_CYCLES = 2 * ARRAY_SIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_data,
    input  logic                             a_valid,
    output logic                             a_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_data,
    output logic                             enable,
    output logic                             load_weights,
    output logic                             clear_acc,
    output logic                             acc_enable,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] weight_inputs_flat,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] input_activations_flat,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0]  results_flat,
    output logic                             r_valid,
    input  logic                             r_ready,
    output logic [ARRAY_SIZE*ACC_WIDTH-1:0]  r_data,
    output logic                             busy,
    output logic                             done
);

    localparam int RW = cnt_w(ARRAY_SIZE);
    localparam int FW = cnt_w(FLUSH_CYCLES);
    localparam logic [RW-1:0] IDX_LAST   = RW'(ARRAY_SIZE - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    state_e state_q, state_d;

    logic [RW-1:0] row_cnt;
    logic [RW-1:0] col_cnt;
    logic [FW-1:0] flush_cnt;

    logic w_beat, a_beat;
    logic row_last, col_last, flush_last;

    assign w_ready = (state_q == S_LOAD_W);
    assign a_ready = (state_q == S_COMPUTE);
    assign r_valid = (state_q == S_OUTPUT);
    assign done    = (state_q == S_DONE);
    assign busy    = (state_q != S_IDLE);

    assign w_beat     = w_valid && w_ready;
    assign a_beat     = a_valid && a_ready;
    assign row_last   = (row_cnt == IDX_LAST);
    assign col_last   = (col_cnt == IDX_LAST);
    assign flush_last = (flush_cnt == FLUSH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_LOAD_W;
            S_LOAD_W:  if (w_beat && row_last) state_d = S_CLEAR;
            S_CLEAR:   state_d = S_COMPUTE;
            S_COMPUTE: if (a_beat && col_last) state_d = S_FLUSH;
            S_FLUSH:   if (flush_last) state_d = S_OUTPUT;
            S_OUTPUT:  if (r_ready) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Counters wrap to zero on their terminal beat so each job starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt   <= '0;
            col_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            if (w_beat) begin
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            end
            if (a_beat) begin
                col_cnt <= col_last ? '0 : col_cnt + 1'b1;
            end
            if (state_q == S_FLUSH) begin
                flush_cnt <= flush_last ? '0 : flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_weights           <= 1'b0;
            weight_inputs_flat     <= '0;
            clear_acc              <= 1'b0;
            enable                 <= 1'b0;
            acc_enable             <= 1'b0;
            input_activations_flat <= '0;
            r_data                 <= '0;
        end else begin
            load_weights       <= w_beat;
            weight_inputs_flat <= w_beat ? w_data : '0;
            clear_acc          <= (state_q == S_CLEAR);
            enable             <= (state_q == S_COMPUTE) || (state_q == S_FLUSH);
            acc_enable         <= (state_q == S_COMPUTE) || (state_q == S_FLUSH);
            input_activations_flat <= a_beat ? a_data : '0;
            if ((state_q == S_FLUSH) && flush_last) begin
                r_data <= results_flat;
            end
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Scoreboard bench for systolic_ctrl: expected array-side traffic is
// queued as stimulus is driven and retired as the DUT emits it.
module tb_systolic_ctrl;
    localparam int N   = 2;
    localparam int DW  = 16;
    localparam int AW  = 32;
    localparam int FL  = 2 * N;
    localparam int WW  = N * DW;
    localparam int RWD = N * AW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           w_valid = 1'b0;
    logic           w_ready;
    logic [WW-1:0]  w_data = '0;
    logic           a_valid = 1'b0;
    logic           a_ready;
    logic [WW-1:0]  a_data = '0;
    logic           enable, load_weights, clear_acc, acc_enable;
    logic [WW-1:0]  weight_inputs_flat;
    logic [WW-1:0]  input_activations_flat;
    logic [RWD-1:0] results_flat = '0;
    logic           r_valid;
    logic           r_ready = 1'b0;
    logic [RWD-1:0] r_data;
    logic           busy, done;

    systolic_ctrl #(
        .ARRAY_SIZE  (N),
        .DATA_WIDTH  (DW),
        .ACC_WIDTH   (AW),
        .FLUSH_CYCLES(FL)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .w_valid               (w_valid),
        .w_ready               (w_ready),
        .w_data                (w_data),
        .a_valid               (a_valid),
        .a_ready               (a_ready),
        .a_data                (a_data),
        .enable                (enable),
        .load_weights          (load_weights),
        .clear_acc             (clear_acc),
        .acc_enable            (acc_enable),
        .weight_inputs_flat    (weight_inputs_flat),
        .input_activations_flat(input_activations_flat),
        .results_flat          (results_flat),
        .r_valid               (r_valid),
        .r_ready               (r_ready),
        .r_data                (r_data),
        .busy                  (busy),
        .done                  (done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int n_load, n_clr, n_en, n_done;

    logic [WW-1:0]  exp_w[$];
    logic [WW-1:0]  exp_a[$];
    logic [RWD-1:0] exp_r[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("acc_en_eq", 64'(acc_enable), 64'(enable));
            if (load_weights) begin
                n_load++;
                if (exp_w.size() == 0) check("w_qdepth", 0, 1);
                else check("w_row", 64'(weight_inputs_flat), 64'(exp_w.pop_front()));
            end else begin
                check("w_zero", 64'(weight_inputs_flat), 0);
            end
            if (enable) begin
                n_en++;
                if (exp_a.size() == 0) check("a_qdepth", 0, 1);
                else check("a_col", 64'(input_activations_flat), 64'(exp_a.pop_front()));
            end else begin
                check("a_zero", 64'(input_activations_flat), 0);
            end
            if (clear_acc) begin
                n_clr++;
                check("clr_no_en", 64'(enable), 0);
            end
            if (done) n_done++;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, 64'({enable, load_weights, clear_acc, acc_enable,
                                 r_valid, busy, done, w_ready, a_ready}), 0);
        check({tag, "_wflat"}, 64'(weight_inputs_flat), 0);
        check({tag, "_aflat"}, 64'(input_activations_flat), 0);
        check({tag, "_rdata"}, 64'(r_data), 0);
    endtask

    task automatic send_w(input logic [WW-1:0] d);
        int t;
        w_valid = 1'b1;
        w_data  = d;
        for (t = 0; t < 50 && !w_ready; t++) @(negedge clk);
        if (t == 50) check("w_timeout", 0, 1);
        else exp_w.push_back(d);
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic send_a(input logic [WW-1:0] d);
        int t;
        a_valid = 1'b1;
        a_data  = d;
        for (t = 0; t < 50 && !a_ready; t++) @(negedge clk);
        if (t == 50) check("a_timeout", 0, 1);
        else exp_a.push_back(d);
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic begin_job(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
        n_load = 0; n_clr = 0; n_en = 0; n_done = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_w(w0);
        send_w(w1);
    endtask

    task automatic run_job(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input logic [WW-1:0] a0, input logic [WW-1:0] a1,
                           input int gap, input int hold,
                           input bit start_in_flush,
                           input logic [RWD-1:0] res);
        int t;
        results_flat = res;
        exp_r.push_back(res);
        begin_job(w0, w1);
        send_a(a0);
        for (int g = 0; g < gap; g++) begin
            exp_a.push_back('0);
            @(negedge clk);
        end
        send_a(a1);
        for (int f = 0; f < FL; f++) exp_a.push_back('0);
        if (start_in_flush) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (t = 0; t < 50 && !r_valid; t++) @(negedge clk);
        if (t == 50) check("r_timeout", 0, 1);
        results_flat = ~res;
        begin
            logic [RWD-1:0] er;
            er = exp_r.pop_front();
            for (int h = 0; h < hold; h++) begin
                check("r_valid_hold", 64'(r_valid), 1);
                check("r_data_hold", 64'(r_data), 64'(er));
                @(negedge clk);
            end
            check("r_data", 64'(r_data), 64'(er));
        end
        r_ready = 1'b1;
        @(negedge clk);
        r_ready = 1'b0;
        check("done_pulse", 64'({done, busy, r_valid}), 64'(3'b110));
        @(negedge clk);
        check("done_drop", 64'({done, busy}), 0);
        repeat (3) @(negedge clk);
        check("stay_idle", 64'(busy), 0);
        check("n_load", 64'(n_load), 2);
        check("n_clr", 64'(n_clr), 1);
        check("n_en", 64'(n_en), 64'(2 + gap + FL));
        check("n_done", 64'(n_done), 1);
        check("q_left", 64'(exp_w.size() + exp_a.size()), 0);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w_valid = 1'b1;
        w_data  = 32'hdead_beef;
        a_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_w", 64'({load_weights, busy}), 0);
        check("idle_no_en", 64'(enable), 0);
        w_valid = 1'b0;
        a_valid = 1'b0;

        run_job({16'd2, 16'd1}, {16'd4, 16'd3}, {16'd7, 16'd5}, {16'd8, 16'd6},
                0, 1, 1'b0, {32'd41, 32'd23});
        run_job({16'd9, 16'd8}, {16'd7, 16'd6}, {16'd1, 16'd2}, {16'd3, 16'd4},
                3, 1, 1'b0, {32'h1234_5678, 32'h9abc_def0});
        run_job({16'h11, 16'h22}, {16'h33, 16'h44}, {16'h55, 16'h66},
                {16'h77, 16'h88}, 0, 10, 1'b0, {32'hcafe_0001, 32'hcafe_0002});

        results_flat = {32'h5555_aaaa, 32'h0f0f_f0f0};
        begin_job({16'd1, 16'd1}, {16'd2, 16'd2});
        send_a({16'd3, 16'd3});
        #2 rst_n = 1'b0;
        #1 check_all_zero("midjob");
        exp_w.delete();
        exp_a.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 64'(busy), 0);

        run_job({16'd5, 16'd6}, {16'd7, 16'd8}, {16'd9, 16'd10}, {16'd11, 16'd12},
                1, 2, 1'b0, {32'd139, 32'd83});
        run_job({16'd2, 16'd1}, {16'd4, 16'd3}, {16'd7, 16'd5}, {16'd8, 16'd6},
                0, 1, 1'b1, {32'hfeed_0042, 32'hbeef_0017});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
